// File: rtl/reg_bus_initiator_if.sv
// Command, response and register-bus signals of reg_bus_initiator.
// master: the initiator side; slave: the environment (command source, response sink, responder).
interface reg_bus_initiator_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] bus_addr;
    logic        bus_re;
    logic        bus_we;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_rdata;
    logic        bus_ready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
               bus_rdata, bus_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, bus_addr, bus_re, bus_we,
               bus_wdata, bus_wstrb
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
               bus_rdata, bus_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, bus_addr, bus_re, bus_we,
               bus_wdata, bus_wstrb
    );
endinterface

// File: rtl/reg_bus_initiator.sv
// Register-bus initiator: buffers read/write commands in a FIFO, issues each as one
// strobed bus access that waits for READY (with timeout), and returns a response.
// Optional macro REG_BUS_ALIGN_CHECK_EN rejects commands with addr[1:0] != 0 without
// touching the bus.
module reg_bus_initiator #(
    parameter int unsigned CMD_DEPTH = 4,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic                clk,
    input  logic                rst_b,
    reg_bus_initiator_if.master bus_if,
    output logic                busy
);

    localparam int unsigned AW = $clog2(CMD_DEPTH);
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StAccess = 2'd1;
    localparam logic [1:0] StResp   = 2'd2;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } cmd_t;

    cmd_t        mem_q [CMD_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        empty, full, push, pop;
    cmd_t        head;

    logic [1:0]  state_q, state_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push  = bus_if.cmd_valid && !full;
    assign pop   = (state_q == StIdle) && !empty;
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    // FIFO storage; contents are meaningless once the pointers say empty, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= '{write: bus_if.cmd_write, addr: bus_if.cmd_addr,
                                         wdata: bus_if.cmd_wdata, wstrb: bus_if.cmd_wstrb};
        end
    end

    // FIFO pointers, one extra bit to tell full from empty.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Transaction FSM next-state: launch from FIFO head, wait/timeout, hold response.
    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (!empty) begin
                    write_d = head.write;
                    addr_d  = head.addr;
                    wdata_d = head.wdata;
                    wstrb_d = head.write ? head.wstrb : 4'h0;
                    cnt_d   = 8'd0;
`ifdef REG_BUS_ALIGN_CHECK_EN
                    if (head.addr[1:0] != 2'b00) begin
                        err_d   = 1'b1;
                        rdata_d = 32'h0;
                        state_d = StResp;
                    end else begin
                        state_d = StAccess;
                    end
`else
                    state_d = StAccess;
`endif
                end
            end
            StAccess: begin
                if (bus_if.bus_ready) begin
                    rdata_d = write_q ? 32'h0 : bus_if.bus_rdata;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    // Counter reaches TIMEOUT on this cycle: abort after TIMEOUT strobe cycles.
                    if (cnt_q == TimeoutLast) begin
                        err_d   = 1'b1;
                        rdata_d = 32'h0;
                        state_d = StResp;
                    end
                end
            end
            StResp: begin
                if (bus_if.rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Transaction FSM state and captured command/response registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= StIdle;
            write_q <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            wstrb_q <= 4'h0;
            cnt_q   <= 8'd0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Strobes decode from state so reset drops them asynchronously.
    always_comb begin
        bus_if.cmd_ready = !full;
        bus_if.bus_re    = (state_q == StAccess) && !write_q;
        bus_if.bus_we    = (state_q == StAccess) && write_q;
        bus_if.bus_addr  = addr_q;
        bus_if.bus_wdata = wdata_q;
        bus_if.bus_wstrb = wstrb_q;
        bus_if.rsp_valid = (state_q == StResp);
        bus_if.rsp_rdata = rdata_q;
        bus_if.rsp_err   = err_q;
        busy             = !empty || (state_q != StIdle);
    end

endmodule

// File: tb/tb_reg_bus_initiator.sv
// Directed bench for reg_bus_initiator (CMD_DEPTH=4, TIMEOUT=15).
// Inputs change and outputs are checked on the falling edge; the DUT acts on the rising edge.
module tb_reg_bus_initiator;

    logic clk;
    logic rst_b;
    logic busy;

    reg_bus_initiator_if ifc ();

    // Responder read data: fixed value, or an address-derived pattern.
    logic        model_rd;
    logic [31:0] rdata_val;
    assign ifc.bus_rdata = model_rd ? (ifc.bus_addr ^ 32'h5A5A_0000) : rdata_val;

    reg_bus_initiator #(
        .CMD_DEPTH(4),
        .TIMEOUT  (15)
    ) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus_if(ifc),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int ncmp  = 0;
    int nfail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_cmd(input logic v, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        ifc.cmd_valid = v;
        ifc.cmd_write = w;
        ifc.cmd_addr  = a;
        ifc.cmd_wdata = d;
        ifc.cmd_wstrb = s;
    endtask

    logic [31:0] exp4 [5];
    logic [31:0] seen_addr;
    int          n;
    int          w;

    initial begin
        exp4 = '{32'h5A5A_0080, 32'h5A5A_0100, 32'h5A5A_0104, 32'h5A5A_0108, 32'h5A5A_010C};
        rst_b         = 1'b0;
        model_rd      = 1'b0;
        rdata_val     = 32'h0;
        ifc.bus_ready = 1'b0;
        ifc.rsp_ready = 1'b0;
        set_cmd(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // Reset state
        tick();
        check("rst_cmd_ready", ifc.cmd_ready, 1);
        check("rst_rsp_valid", ifc.rsp_valid, 0);
        check("rst_bus_re", ifc.bus_re, 0);
        check("rst_bus_we", ifc.bus_we, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp_rdata", ifc.rsp_rdata, 0);
        check("rst_rsp_err", ifc.rsp_err, 0);
        check("rst_bus_addr", ifc.bus_addr, 0);
        rst_b = 1'b1;
        tick();

        // Write with immediate READY: one bus_we cycle, strobe two cycles after push
        ifc.bus_ready = 1'b1;
        set_cmd(1'b1, 1'b1, 32'h0, 32'hFEED_BEEF, 4'hF);
        tick();
        set_cmd(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        check("t1_we_not_yet", ifc.bus_we, 0);
        check("t1_busy", busy, 1);
        tick();
        check("t1_bus_we", ifc.bus_we, 1);
        check("t1_bus_re", ifc.bus_re, 0);
        check("t1_bus_addr", ifc.bus_addr, 32'h0);
        check("t1_bus_wdata", ifc.bus_wdata, 32'hFEED_BEEF);
        check("t1_bus_wstrb", ifc.bus_wstrb, 4'hF);
        tick();
        check("t1_we_dropped", ifc.bus_we, 0);
        check("t1_rsp_valid", ifc.rsp_valid, 1);
        check("t1_rsp_err", ifc.rsp_err, 0);
        check("t1_rsp_rdata", ifc.rsp_rdata, 0);
        ifc.rsp_ready = 1'b1;
        tick();
        ifc.rsp_ready = 1'b0;
        check("t1_rsp_done", ifc.rsp_valid, 0);
        check("t1_idle", busy, 0);

        // Read 0x40, READY two cycles after bus_re rises: bus_re held three cycles
        ifc.bus_ready = 1'b0;
        rdata_val     = 32'h0BAD_C0DE;
        set_cmd(1'b1, 1'b0, 32'h40, 32'h1234_5678, 4'hF);
        tick();
        set_cmd(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        check("t2_re_c0", ifc.bus_re, 1);
        check("t2_addr_c0", ifc.bus_addr, 32'h40);
        check("t2_wstrb_read", ifc.bus_wstrb, 4'h0);
        tick();
        check("t2_re_c1", ifc.bus_re, 1);
        check("t2_addr_c1", ifc.bus_addr, 32'h40);
        tick();
        check("t2_re_c2", ifc.bus_re, 1);
        check("t2_addr_c2", ifc.bus_addr, 32'h40);
        ifc.bus_ready = 1'b1;
        tick();
        ifc.bus_ready = 1'b0;
        check("t2_re_dropped", ifc.bus_re, 0);
        check("t2_rsp_valid", ifc.rsp_valid, 1);
        check("t2_rsp_rdata", ifc.rsp_rdata, 32'h0BAD_C0DE);
        check("t2_rsp_err", ifc.rsp_err, 0);
        ifc.rsp_ready = 1'b1;
        tick();
        ifc.rsp_ready = 1'b0;

        // Read 0x10 never acknowledged: 15 strobe cycles then error; queued write follows
        rdata_val = 32'hDEAD_DEAD;
        set_cmd(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        tick();
        set_cmd(1'b1, 1'b1, 32'h20, 32'hA1B2_C3D4, 4'h3);
        tick();
        set_cmd(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        n = 0;
        for (int i = 0; i < 40 && !ifc.rsp_valid; i++) begin
            if (ifc.bus_re && ifc.bus_addr == 32'h10) n++;
            tick();
        end
        check("t3_rsp_valid", ifc.rsp_valid, 1);
        check("t3_re_cycles", n, 15);
        check("t3_re_dropped", ifc.bus_re, 0);
        check("t3_rsp_err", ifc.rsp_err, 1);
        check("t3_rsp_rdata", ifc.rsp_rdata, 0);
        ifc.bus_ready = 1'b1;
        ifc.rsp_ready = 1'b1;
        tick();
        ifc.rsp_ready = 1'b0;
        check("t3_rsp_done", ifc.rsp_valid, 0);
        tick();
        check("t3_next_we", ifc.bus_we, 1);
        check("t3_next_addr", ifc.bus_addr, 32'h20);
        check("t3_next_wstrb", ifc.bus_wstrb, 4'h3);
        tick();
        check("t3_next_rsp_valid", ifc.rsp_valid, 1);
        check("t3_next_rsp_err", ifc.rsp_err, 0);
        ifc.rsp_ready = 1'b1;
        tick();
        ifc.rsp_ready = 1'b0;

        // Back-pressure: response for 0x80 held, then five pushes; only four fit the FIFO
        model_rd = 1'b1;
        set_cmd(1'b1, 1'b0, 32'h80, 32'h0, 4'h0);
        tick();
        set_cmd(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        tick();
        check("t4_first_valid", ifc.rsp_valid, 1);
        for (int i = 0; i < 5; i++) begin
            set_cmd(1'b1, 1'b0, 32'h100 + 32'(4 * i), 32'h0, 4'h0);
            check("t4_cmd_ready", ifc.cmd_ready, (i < 4) ? 1 : 0);
            check("t4_first_hold", ifc.rsp_rdata, 32'h5A5A_0080);
            tick();
        end
        set_cmd(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        check("t4_still_full", ifc.cmd_ready, 0);
        ifc.rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            w = 0;
            while (!ifc.rsp_valid && w < 10) begin
                tick();
                w++;
            end
            check("t4_drain_valid", ifc.rsp_valid, 1);
            check("t4_drain_rdata", ifc.rsp_rdata, exp4[k]);
            check("t4_drain_err", ifc.rsp_err, 0);
            tick();
        end
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (ifc.rsp_valid) n++;
            tick();
        end
        ifc.rsp_ready = 1'b0;
        check("t4_no_extra_rsp", n, 0);
        check("t4_idle", busy, 0);

        // Reset during a write access with a second write queued
        ifc.bus_ready = 1'b0;
        set_cmd(1'b1, 1'b1, 32'h30, 32'h5555_AAAA, 4'hF);
        tick();
        set_cmd(1'b1, 1'b1, 32'h34, 32'h6666_BBBB, 4'hF);
        tick();
        set_cmd(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        check("t5_we_before", ifc.bus_we, 1);
        check("t5_addr_before", ifc.bus_addr, 32'h30);
        #2 rst_b = 1'b0;
        #1;
        check("t5_we_async", ifc.bus_we, 0);
        check("t5_busy_async", busy, 0);
        check("t5_rsp_valid_async", ifc.rsp_valid, 0);
        check("t5_cmd_ready_async", ifc.cmd_ready, 1);
        tick();
        rst_b = 1'b1;
        ifc.bus_ready = 1'b1;
        ifc.rsp_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (ifc.rsp_valid || ifc.bus_we || ifc.bus_re) n++;
            tick();
        end
        ifc.rsp_ready = 1'b0;
        check("t5_no_stale_activity", n, 0);
        check("t5_idle", busy, 0);

        // Misaligned read 0x6
        set_cmd(1'b1, 1'b0, 32'h6, 32'h0, 4'h0);
        tick();
        set_cmd(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        n         = 0;
        seen_addr = 32'hFFFF_FFFF;
        for (int i = 0; i < 10 && !ifc.rsp_valid; i++) begin
            if (ifc.bus_re) begin
                n++;
                seen_addr = ifc.bus_addr;
            end
            tick();
        end
        check("t6_rsp_valid", ifc.rsp_valid, 1);
`ifdef REG_BUS_ALIGN_CHECK_EN
        check("t6_no_re", n, 0);
        check("t6_rsp_err", ifc.rsp_err, 1);
        check("t6_rsp_rdata", ifc.rsp_rdata, 0);
`else
        check("t6_re_cycles", n, 1);
        check("t6_re_addr", seen_addr, 32'h6);
        check("t6_rsp_err", ifc.rsp_err, 0);
        check("t6_rsp_rdata", ifc.rsp_rdata, 32'h5A5A_0006);
`endif
        ifc.rsp_ready = 1'b1;
        tick();
        ifc.rsp_ready = 1'b0;
        check("t6_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/reg_bus_initiator.md
Name: reg_bus_initiator

Overview:
- Bus initiator for the 32-bit register/memory bus (ADDR, RE, WE, WSTRB, DATA_WR, DATA_RD, READY) that the register-block responders decode.
- Accepts read/write commands on a valid/ready command port and buffers them in a small FIFO.
- Issues each command as a single bus access, then waits for READY, with a timeout.
- Returns read data and an error flag on a valid/ready response port.
- Replaces ad-hoc count-driven stimulus in benches and serves as the CPU-side bridge in subsystems.

Parameters:
- CMD_DEPTH, 4, command FIFO entries; power of two, minimum 2.
- TIMEOUT, 15, maximum cycles in ACCESS waiting for bus_ready before abort; 1..255.

Ports:
- clk  in  1  clock
- rst_b  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO not full
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  32  byte address
- cmd_wdata  in  32  write data
- cmd_wstrb  in  4  byte strobes (writes only)
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  32  read data; 0 for writes and errors
- rsp_err  out  1  timeout or rejected access
- bus_addr  out  32  to responder ADDR
- bus_re  out  1  to responder RE
- bus_we  out  1  to responder WE
- bus_wdata  out  32  to responder DATA_WR
- bus_wstrb  out  4  to responder WSTRB
- bus_rdata  in  32  from responder DATA_RD
- bus_ready  in  1  from responder READY
- busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Single clock domain, clk.
- Reset is asynchronous, active-low, on rst_b.
- Reset values: all outputs 0 except cmd_ready=1. FIFO is empty, FSM is IDLE, timeout counter is 0.
- Command FIFO:
  - A push occurs when cmd_valid && cmd_ready.
  - cmd_ready = !full.
  - Pointers are log2(CMD_DEPTH)+1 bits and wrap naturally.
  - A push and a pop in the same cycle while full is allowed; cmd_ready still reflects full, so no push is accepted when full.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If the FIFO is non-empty, pop the head, register it into bus_addr, bus_wdata and bus_wstrb, and go to ACCESS.
  - Latency: a command pushed at cycle N (FIFO previously empty, FSM IDLE) has its strobe asserted at cycle N+2.
- ACCESS:
  - bus_we=cmd_write, bus_re=!cmd_write. The strobe holds with stable addr/data until exit.
  - bus_ready is sampled each cycle, including the first ACCESS cycle. This supports combinational-READY registers and registered-READY memories.
  - On bus_ready=1: capture bus_rdata (reads) or 0 (writes), set rsp_err=0, drop the strobe next cycle, go to RESP.
  - Otherwise the counter increments. When the counter equals TIMEOUT with bus_ready still 0, set rsp_err=1 and rsp_rdata=0, drop the strobe, go to RESP.
  - The counter clears on ACCESS entry.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_ready.
  - On rsp_valid && rsp_ready, go to IDLE.
  - Back-to-back: IDLE with a non-empty FIFO re-enters ACCESS on the following cycle. Minimum 3 cycles per transaction.
- bus_re and bus_we are never both 1. Both are 0 outside ACCESS.
- bus_wstrb is driven as 0 on reads.
- Reset mid-transaction: all state clears immediately and outputs return to reset values. The pending command and FIFO contents are discarded; no response is produced.
- bus_ready is ignored outside ACCESS.

Optional Feature:
- Macro: REG_BUS_ALIGN_CHECK_EN.
- Defined:
  - In IDLE, a popped command with cmd_addr[1:0]!=0 skips ACCESS and goes straight to RESP.
  - The response is rsp_err=1, rsp_rdata=0.
  - No bus strobe is asserted.
- Undefined: no alignment check; all commands are issued on the bus unchanged.

Test Plan:
- Write addr 0x0, data 0xFEEDBEEF, wstrb 0xF, bus_ready tied 1 in ACCESS -> one-cycle bus_we with bus_addr=0, bus_wdata=0xFEEDBEEF; rsp_valid with rsp_err=0, rsp_rdata=0.
- Read addr 0x40, responder asserts bus_ready 2 cycles after bus_re with bus_rdata=0x0BADC0DE -> bus_re held 3 cycles with stable addr; rsp_rdata=0x0BADC0DE, rsp_err=0.
- Read addr 0x10 with bus_ready held 0 -> bus_re drops after the TIMEOUT=15 counter expires; rsp_err=1, rsp_rdata=0; the next queued command proceeds normally.
- Push 5 commands back-to-back with rsp_ready=0 -> cmd_ready deasserts after 4 accepted; the first response holds stable; releasing rsp_ready drains all responses in order with no loss or duplication.
- Assert rst_b=0 mid-ACCESS of a write -> bus_we, busy and rsp_valid go 0 asynchronously, cmd_ready=1; after release no stale response appears.
- With REG_BUS_ALIGN_CHECK_EN, read addr 0x6 -> no bus_re pulse; rsp_err=1. Without the macro -> bus_re issued with bus_addr=0x6.
